// File: rtl/befehl_ablaufsteuerung_if.sv
// Fetch/execute handshake between the instruction sequencer, the instruction
// memory port and the execute unit.
interface befehl_ablaufsteuerung_if #(
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32
);
   logic                  SpeicherAnfrage;
   logic                  SpeicherBereit;
   logic [DATA_WIDTH-1:0] Befehlswort;
   logic [DATA_WIDTH-1:0] Befehl;
   logic                  BefehlGueltig;
   logic                  AusfuehrungFertig;
   logic                  SprungGueltig;
   logic [ADDR_WIDTH-1:0] SprungZiel;

   modport master (
      output SpeicherAnfrage, Befehl, BefehlGueltig,
      input  SpeicherBereit, Befehlswort, AusfuehrungFertig, SprungGueltig, SprungZiel
   );

   modport slave (
      input  SpeicherAnfrage, Befehl, BefehlGueltig,
      output SpeicherBereit, Befehlswort, AusfuehrungFertig, SprungGueltig, SprungZiel
   );
endinterface

// File: rtl/befehl_ablaufsteuerung.sv
// Fetch/execute/advance sequencer driving the PC register, one TaktSignal per retired
// instruction. Define BEFEHLSZAEHLER_EN to add the 32-bit retired-instruction counter.
module befehl_ablaufsteuerung #(
   parameter int ADDR_WIDTH    = 26,
   parameter int DATA_WIDTH    = 32,
   parameter int FETCH_TIMEOUT = 255
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  HaltAnfrage,
   befehl_ablaufsteuerung_if.master bus,
   output logic                  TaktSignal,
   output logic                  SchreibSignal,
   output logic [ADDR_WIDTH-1:0] NeuerPC,
   output logic                  Angehalten,
   output logic                  Fehler,
   output logic [2:0]            Zustand
`ifdef BEFEHLSZAEHLER_EN
   ,output logic [31:0]          BefehlsZaehler
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      STEP  = 3'd3,
      FAULT = 3'd4
   } zustand_t;

   localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

   zustand_t              zustand;
   logic [CNT_W-1:0]      warte_cnt;
   logic [DATA_WIDTH-1:0] befehl_q;
   logic                  gueltig_q;
   logic                  sprung_q;
   logic                  halt_q;
   logic [ADDR_WIDTH-1:0] neuer_pc_q;
`ifdef BEFEHLSZAEHLER_EN
   logic [31:0]           zaehler_q;
`endif

   // The PC register adds one to whatever it loads, so a jump hands over target-1.
   function automatic logic [ADDR_WIDTH-1:0] ladewert(input logic sprung,
                                                      input logic [ADDR_WIDTH-1:0] ziel);
      return sprung ? ziel - 1'b1 : '0;
   endfunction

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         zustand    <= IDLE;
         warte_cnt  <= '0;
         befehl_q   <= '0;
         gueltig_q  <= 1'b0;
         sprung_q   <= 1'b0;
         halt_q     <= 1'b0;
         neuer_pc_q <= '0;
      end else begin
         gueltig_q <= 1'b0;
         if (HaltAnfrage && zustand != IDLE)
            halt_q <= 1'b1;
         case (zustand)
            IDLE: begin
               if (Start) begin
                  warte_cnt <= '0;
                  zustand   <= FETCH;
               end
            end
            FETCH: begin
               // Data arriving on the last allowed cycle takes priority over the timeout.
               if (bus.SpeicherBereit) begin
                  befehl_q  <= bus.Befehlswort;
                  gueltig_q <= 1'b1;
                  zustand   <= EXEC;
               end else if (warte_cnt == CNT_LAST) begin
                  zustand <= FAULT;
               end else begin
                  warte_cnt <= warte_cnt + 1'b1;
               end
            end
            EXEC: begin
               if (bus.AusfuehrungFertig) begin
                  sprung_q   <= bus.SprungGueltig;
                  neuer_pc_q <= ladewert(bus.SprungGueltig, bus.SprungZiel);
                  zustand    <= STEP;
               end
            end
            STEP: begin
               sprung_q   <= 1'b0;
               neuer_pc_q <= '0;
               if (halt_q) begin
                  halt_q  <= 1'b0;
                  zustand <= IDLE;
               end else begin
                  warte_cnt <= '0;
                  zustand   <= FETCH;
               end
            end
            FAULT: begin
               if (Start) begin
                  halt_q   <= 1'b0;
                  sprung_q <= 1'b0;
                  zustand  <= IDLE;
               end
            end
            default: zustand <= IDLE;
         endcase
      end
   end

`ifdef BEFEHLSZAEHLER_EN
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         zaehler_q <= '0;
      else if (zustand == STEP)
         zaehler_q <= zaehler_q + 32'd1;
   end

   assign BefehlsZaehler = zaehler_q;
`endif

   assign bus.SpeicherAnfrage = (zustand == FETCH);
   assign bus.Befehl          = befehl_q;
   assign bus.BefehlGueltig   = gueltig_q;
   assign TaktSignal          = (zustand == STEP);
   assign SchreibSignal       = (zustand == STEP) && sprung_q;
   assign NeuerPC             = neuer_pc_q;
   assign Angehalten          = (zustand == IDLE);
   assign Fehler              = (zustand == FAULT);
   assign Zustand             = zustand;

endmodule
